// File: rtl/audio_play_engine_pkg.sv
// Shared audio types: playback state encoding and default bus widths,
// also imported by the record engine.
package audio_play_engine_pkg;

   localparam int unsigned DEF_ADDR_W = 23;
   localparam int unsigned DEF_DATA_W = 16;

   typedef logic [DEF_DATA_W-1:0] SAMPLE_T;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      READY,
      PAUSED,
      DONE
   } play_state_t;

endpackage

// File: rtl/audio_play_engine_rise.sv
// 1-bit rising-edge detector with a registered previous value.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic rise
);

   logic prev;
   logic armed;

   // The first clock after reset only captures the level, so an input
   // already high across reset release is not mistaken for a new edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev  <= 1'b0;
         armed <= 1'b0;
      end else begin
         prev  <= level;
         armed <= 1'b1;
      end
   end

   assign rise = armed & level & ~prev;

endmodule

// File: rtl/audio_play_engine.sv
// Playback engine: fetches samples over a request/valid read port and
// presents one per sample tick to the DAC, reporting completion to the controller.
module audio_play_engine
   import audio_play_engine_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_play_start,
   input  logic [ADDR_W-1:0] i_play_select,
   input  logic [ADDR_W-1:0] i_play_end,
   input  logic              i_play_pause,
   input  logic              i_play_stop,
   output logic              o_play_done,
   output logic              o_mem_read,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic              i_mem_valid,
   input  logic [DATA_W-1:0] i_mem_data,
   input  logic              i_sample_tick,
   output logic [DATA_W-1:0] o_dac_data,
   output logic              o_dac_valid,
   output logic              o_underrun
);

   play_state_t       state, state_n;
   logic [ADDR_W-1:0] addr, addr_n;
   logic [ADDR_W-1:0] end_addr, end_n;
   logic [DATA_W-1:0] buffer, buffer_n;
   logic [DATA_W-1:0] dac_data, dac_data_n;
   logic              dac_valid, dac_valid_n;
   logic              underrun, underrun_n;
   logic              done, done_n;
   logic              stop_pend, stop_pend_n;
   logic              start_rise;

   rise_detect u_start_rise (
      .clk   (i_clk),
      .rst   (i_rst),
      .level (i_play_start),
      .rise  (start_rise)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         addr      <= '0;
         end_addr  <= '0;
         buffer    <= '0;
         dac_data  <= '0;
         dac_valid <= 1'b0;
         underrun  <= 1'b0;
         done      <= 1'b0;
         stop_pend <= 1'b0;
      end else begin
         state     <= state_n;
         addr      <= addr_n;
         end_addr  <= end_n;
         buffer    <= buffer_n;
         dac_data  <= dac_data_n;
         dac_valid <= dac_valid_n;
         underrun  <= underrun_n;
         done      <= done_n;
         stop_pend <= stop_pend_n;
      end
   end

   always_comb begin
      state_n     = state;
      addr_n      = addr;
      end_n       = end_addr;
      buffer_n    = buffer;
      dac_data_n  = dac_data;
      dac_valid_n = 1'b0;
      underrun_n  = underrun;
      done_n      = (state == DONE);
      stop_pend_n = stop_pend;

      unique case (state)
         IDLE: begin
            if (start_rise) begin
               addr_n      = i_play_select;
               end_n       = i_play_end;
               underrun_n  = 1'b0;
               stop_pend_n = 1'b0;
               state_n     = (i_play_select >= i_play_end) ? DONE : FETCH;
            end
         end
         FETCH: begin
            if (i_sample_tick) underrun_n = 1'b1;
            if (i_play_stop) stop_pend_n = 1'b1;
            // A stop seen at any point during the read is remembered; the bus
            // transaction still runs to completion and its data is dropped.
            if (i_mem_valid) begin
               addr_n = addr + 1'b1;
               if (i_play_stop || stop_pend) begin
                  state_n = DONE;
               end else begin
                  buffer_n = i_mem_data;
                  state_n  = i_play_pause ? PAUSED : READY;
               end
            end
         end
         READY: begin
            if (i_play_stop) begin
               state_n = DONE;
            end else if (i_play_pause) begin
               state_n = PAUSED;
            end else if (i_sample_tick) begin
               dac_data_n  = buffer;
               dac_valid_n = 1'b1;
               state_n     = (addr == end_addr) ? DONE : FETCH;
            end
         end
         PAUSED: begin
            if (i_play_stop) state_n = DONE;
            else if (!i_play_pause) state_n = READY;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      o_mem_read = (state == FETCH);
      o_mem_addr = (state == FETCH) ? addr : '0;
   end

   assign o_dac_data  = dac_data;
   assign o_dac_valid = dac_valid;
   assign o_underrun  = underrun;
   assign o_play_done = done;

endmodule

// File: tb/tb_audio_play_engine.sv
// Directed bench for audio_play_engine with a latency-configurable memory
// responder and a periodic sample-tick source.
module tb_audio_play_engine;

   logic        clk;
   logic        rst;
   logic        play_start;
   logic [22:0] play_select;
   logic [22:0] play_end;
   logic        play_pause;
   logic        play_stop;
   logic        play_done;
   logic        mem_read;
   logic [22:0] mem_addr;
   logic        mem_valid;
   logic [15:0] mem_data;
   logic        sample_tick;
   logic [15:0] dac_data;
   logic        dac_valid;
   logic        underrun;

   int          checks;
   int          failures;
   int          mem_lat;
   int          mem_cnt;
   int          tick_per;
   int          tcnt;
   bit          tick_en;
   int          dac_cnt;
   int          done_cnt;
   logic [15:0] dac_log[$];

   audio_play_engine #(.ADDR_W(23), .DATA_W(16)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_play_start  (play_start),
      .i_play_select (play_select),
      .i_play_end    (play_end),
      .i_play_pause  (play_pause),
      .i_play_stop   (play_stop),
      .o_play_done   (play_done),
      .o_mem_read    (mem_read),
      .o_mem_addr    (mem_addr),
      .i_mem_valid   (mem_valid),
      .i_mem_data    (mem_data),
      .i_sample_tick (sample_tick),
      .o_dac_data    (dac_data),
      .o_dac_valid   (dac_valid),
      .o_underrun    (underrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: returns 0xA000+addr after mem_lat cycles of request.
   initial begin
      mem_valid = 1'b0;
      mem_data  = '0;
      mem_cnt   = 0;
      forever begin
         @(negedge clk);
         mem_valid = 1'b0;
         if (mem_read) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
               mem_valid = 1'b1;
               mem_data  = 16'hA000 + mem_addr[15:0];
               mem_cnt   = 0;
            end
         end else begin
            mem_cnt = 0;
         end
      end
   end

   initial begin
      sample_tick = 1'b0;
      tcnt        = 0;
      forever begin
         @(negedge clk);
         sample_tick = 1'b0;
         if (tick_en) begin
            tcnt++;
            if (tcnt >= tick_per) begin
               sample_tick = 1'b1;
               tcnt        = 0;
            end
         end
      end
   end

   initial begin
      dac_cnt  = 0;
      done_cnt = 0;
      forever begin
         @(negedge clk);
         if (dac_valid) begin
            dac_cnt++;
            dac_log.push_back(dac_data);
         end
         if (play_done) done_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int budget, input string tag);
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         step();
         n++;
      end
      check(tag, 32'(done_cnt - d0), 32'd1);
   endtask

   task automatic wait_dac(input int budget, input string tag, input logic [15:0] exp);
      int n;
      n = 0;
      step();
      while (!dac_valid && n < budget) begin
         step();
         n++;
      end
      check({tag, "_seen"}, 32'(dac_valid), 32'd1);
      check({tag, "_data"}, 32'(dac_data), 32'(exp));
   endtask

   initial begin
      int n0;
      int d0;
      int bad;
      int n;
      checks      = 0;
      failures    = 0;
      rst         = 1'b1;
      play_start  = 1'b0;
      play_select = '0;
      play_end    = '0;
      play_pause  = 1'b0;
      play_stop   = 1'b0;
      mem_lat     = 3;
      tick_per    = 20;
      tick_en     = 1'b0;

      // Reset state
      step();
      step();
      check("rst_mem_read", 32'(mem_read), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_dac_data", 32'(dac_data), 32'd0);
      check("rst_dac_valid", 32'(dac_valid), 32'd0);
      check("rst_done", 32'(play_done), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      rst = 1'b0;
      step();
      step();

      // Basic run 0x10..0x12
      n0          = dac_log.size();
      play_select = 23'h10;
      play_end    = 23'h13;
      tcnt        = 0;
      tick_en     = 1'b1;
      play_start  = 1'b1;
      step();
      check("basic_read", 32'(mem_read), 32'd1);
      check("basic_addr", 32'(mem_addr), 32'h10);
      wait_done(300, "basic_done");
      check("basic_count", 32'(dac_log.size() - n0), 32'd3);
      if (dac_log.size() - n0 >= 3) begin
         check("basic_s0", 32'(dac_log[n0]), 32'hA010);
         check("basic_s1", 32'(dac_log[n0+1]), 32'hA011);
         check("basic_s2", 32'(dac_log[n0+2]), 32'hA012);
      end
      check("basic_underrun", 32'(underrun), 32'd0);
      d0 = done_cnt;
      step();
      check("basic_idle_done", 32'(play_done), 32'd0);
      check("basic_idle_read", 32'(mem_read), 32'd0);
      // Start still held high: no restart.
      for (int i = 0; i < 10; i++) step();
      check("basic_no_restart", 32'(done_cnt - d0), 32'd0);
      play_start = 1'b0;
      step();

      // Empty range
      play_select = 23'h20;
      play_end    = 23'h20;
      tick_en     = 1'b0;
      bad         = 0;
      play_start  = 1'b1;
      step();
      if (mem_read) bad++;
      check("empty_done_c1", 32'(play_done), 32'd0);
      step();
      if (mem_read) bad++;
      check("empty_done_c2", 32'(play_done), 32'd1);
      step();
      if (mem_read) bad++;
      check("empty_done_c3", 32'(play_done), 32'd0);
      check("empty_no_read", 32'(bad), 32'd0);
      play_start = 1'b0;
      step();

      // Pause during FETCH of 0x11
      play_select = 23'h10;
      play_end    = 23'h13;
      tcnt        = 0;
      tick_en     = 1'b1;
      play_start  = 1'b1;
      wait_dac(60, "pause_first", 16'hA010);
      check("pause_in_fetch", 32'(mem_read), 32'd1);
      play_pause = 1'b1;
      bad        = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (dac_valid) bad++;
         if (underrun) bad++;
      end
      check("pause_quiet", 32'(bad), 32'd0);
      check("pause_read_done", 32'(mem_read), 32'd0);
      play_pause = 1'b0;
      wait_dac(60, "pause_resume", 16'hA011);
      wait_done(200, "pause_done");
      check("pause_last", 32'(dac_data), 32'hA012);
      play_start = 1'b0;
      step();

      // Stop during outstanding read
      mem_lat     = 5;
      play_select = 23'h30;
      play_end    = 23'h34;
      play_start  = 1'b1;
      step();
      check("stop_read", 32'(mem_read), 32'd1);
      play_stop = 1'b1;
      n0        = dac_cnt;
      bad       = 0;
      n         = 0;
      do begin
         step();
         if (mem_read !== 1'b1) bad++;
         n++;
      end while (!mem_valid && n < 20);
      check("stop_valid_seen", 32'(mem_valid), 32'd1);
      check("stop_read_held", 32'(bad), 32'd0);
      step();
      check("stop_read_drop", 32'(mem_read), 32'd0);
      check("stop_done_c1", 32'(play_done), 32'd0);
      step();
      check("stop_done_c2", 32'(play_done), 32'd1);
      step();
      check("stop_done_c3", 32'(play_done), 32'd0);
      for (int i = 0; i < 30; i++) step();
      check("stop_no_dac", 32'(dac_cnt - n0), 32'd0);
      play_stop  = 1'b0;
      play_start = 1'b0;
      step();

      // Underrun: latency 30, tick period 20
      mem_lat     = 30;
      tick_per    = 20;
      tcnt        = 0;
      play_select = 23'h40;
      play_end    = 23'h42;
      n0          = dac_cnt;
      play_start  = 1'b1;
      step();
      check("urun_initial", 32'(underrun), 32'd0);
      n = 0;
      while (!underrun && n < 40) begin
         step();
         n++;
      end
      check("urun_set", 32'(underrun), 32'd1);
      check("urun_no_dac", 32'(dac_cnt - n0), 32'd0);
      play_stop = 1'b1;
      wait_done(60, "urun_stop_done");
      play_stop = 1'b0;
      step();
      check("urun_sticky", 32'(underrun), 32'd1);
      play_start = 1'b0;
      step();
      play_select = 23'h20;
      play_end    = 23'h20;
      play_start  = 1'b1;
      step();
      check("urun_cleared", 32'(underrun), 32'd0);
      wait_done(10, "urun_empty_done");
      play_start = 1'b0;
      step();

      // Reset mid-READY with start held across release
      mem_lat     = 3;
      tcnt        = 0;
      play_select = 23'h50;
      play_end    = 23'h52;
      play_start  = 1'b1;
      wait_dac(60, "rstm_first", 16'hA050);
      for (int i = 0; i < 5; i++) step();
      check("rstm_ready", 32'(mem_read), 32'd0);
      #1;
      rst = 1'b1;
      #1;
      check("rstm_dac_data", 32'(dac_data), 32'd0);
      check("rstm_dac_valid", 32'(dac_valid), 32'd0);
      check("rstm_done", 32'(play_done), 32'd0);
      check("rstm_underrun", 32'(underrun), 32'd0);
      check("rstm_mem_read", 32'(mem_read), 32'd0);
      step();
      step();
      rst = 1'b0;
      d0  = done_cnt;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (mem_read) bad++;
      end
      check("rstm_no_restart", 32'(bad), 32'd0);
      check("rstm_no_done", 32'(done_cnt - d0), 32'd0);
      play_start = 1'b0;
      step();
      play_start = 1'b1;
      step();
      check("rstm_restart_read", 32'(mem_read), 32'd1);
      check("rstm_restart_addr", 32'(mem_addr), 32'h50);
      wait_done(200, "rstm_done_pulse");
      check("rstm_last", 32'(dac_data), 32'hA051);
      play_start = 1'b0;
      tick_en    = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/audio_play_engine.md
# audio_play_engine

Playback responder for the control core's play handshake. It accepts start/select/pause/stop from the controller, fetches 16-bit samples from external memory through a request/valid read port, and presents one sample per sample-rate tick to the DAC serializer. It signals completion back to the controller on `o_play_done`.

## Interface
- ADDR_W, 23, word address width; matches the control core's `play_select`
- DATA_W, 16, sample width
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_play_start  in  1  level from controller; a rising edge starts playback
- i_play_select  in  ADDR_W  first sample address; latched on the start edge
- i_play_end  in  ADDR_W  exclusive end address; latched on the start edge
- i_play_pause  in  1  level; holds playback while high
- i_play_stop  in  1  level; aborts playback
- o_play_done  out  1  one-cycle pulse when playback ends or is stopped
- o_mem_read  out  1  read request; held high until accepted
- o_mem_addr  out  ADDR_W  read address
- i_mem_valid  in  1  one-cycle pulse; `i_mem_data` is valid and the request is complete
- i_mem_data  in  DATA_W  read data
- i_sample_tick  in  1  one-cycle strobe at the sample rate
- o_dac_data  out  DATA_W  current sample
- o_dac_valid  out  1  one-cycle pulse when a new sample is presented
- o_underrun  out  1  sticky flag; a tick arrived with no sample buffered

## Operation
- States: IDLE, FETCH, READY, PAUSED, DONE.
- Reset values:
  - state=IDLE
  - all outputs 0
  - internal start_d=0, buffer=0, addr=0, end=0
- IDLE: on `i_play_start & ~start_d`:
  - latch addr=`i_play_select` and end=`i_play_end`
  - clear `o_underrun`
  - go to DONE if select>=end (unsigned), else go to FETCH
- FETCH:
  - `o_mem_read`=1 and `o_mem_addr`=addr
  - on `i_mem_valid`: buffer<=`i_mem_data`, addr<=addr+1 (wraps mod 2^ADDR_W), go to READY
- READY: on `i_sample_tick`:
  - `o_dac_data`<=buffer and `o_dac_valid`<=1
  - if addr==end go to DONE, else go to FETCH
- Tick while in FETCH: `o_dac_data` is held, `o_dac_valid` stays 0, and `o_underrun`<=1. The fetch continues.
- Pause:
  - In READY, `i_play_pause` goes to PAUSED.
  - In FETCH, the outstanding read completes first, then the engine goes to PAUSED instead of READY. The buffer keeps the fetched word.
  - PAUSED ignores ticks and raises no underrun. When pause falls, the engine returns to READY.
- Stop:
  - From READY or PAUSED, `i_play_stop` goes to DONE on the next edge.
  - In FETCH, stop never aborts a bus transaction. The engine waits for `i_mem_valid`, discards the data, and goes to DONE.
- Priority within a cycle: stop > pause > tick. Stop and tick in the same READY cycle: no sample is output.
- DONE: `o_play_done`=1 for exactly one cycle, then IDLE. `o_dac_data` holds its last value.
- A start edge outside IDLE is ignored. start_d tracks `i_play_start` every cycle, so a level held high through DONE does not restart playback.
- Pause or stop asserted in IDLE has no effect.

## Timing
- Start edge sampled at edge N: `o_mem_read` is high from cycle N+1 with `o_mem_addr`=select.
- `i_mem_valid` at edge M: READY from M+1, so the earliest accepted tick is M+1.
- Tick sampled at edge T: `o_dac_data`/`o_dac_valid` are registered outputs at T+1.
- `o_play_done` is registered: high during the cycle after DONE is entered.
- Minimum per-sample cost is 2 cycles of memory plus the tick. Underrun-free operation requires memory latency < tick period − 2.
- Reset mid-operation returns to IDLE immediately and drops `o_mem_read` asynchronously. The memory side must tolerate an abandoned request.

## Structure
- The shared audio package holds:
  - the state enum `play_state_t`
  - ADDR_W and DATA_W defaults
  - `SAMPLE_T` typedef `logic [DATA_W-1:0]`
- The package is also used by the record engine.
- Optional sub-module: `rise_detect`, a 1-bit edge detector with registered previous value, reused for `i_play_start` and by the record engine.
- All other logic is a single always_ff state register plus combinational next-state logic.

## Test plan
- Basic run: select=0x10, end=0x13, memory returns 0xA000+addr after 3 cycles, ticks every 20 cycles.
  - Required: three `o_dac_valid` pulses carrying 0xA010, 0xA011, 0xA012, then one `o_play_done` pulse, then IDLE.
- Empty range: select=0x20, end=0x20.
  - Required: `o_play_done` 2 cycles after the start edge, `o_mem_read` never asserted.
- Pause: pause raised mid-FETCH of 0x11, held for 100 cycles.
  - Required: the read completes, no `o_dac_valid` while paused, `o_underrun` stays 0.
  - After release: next tick outputs 0xA011.
- Stop during outstanding read (valid delayed 5 cycles).
  - Required: `o_mem_read` held until valid, `o_play_done` the cycle after DONE entry, no further `o_dac_valid`.
- Underrun: memory latency 30 cycles with tick period 20.
  - Required: `o_underrun`=1 after the first missed tick.
  - Required: the next start edge clears it.
- Reset mid-READY, then `i_play_start` held high across reset release.
  - Required: outputs return to 0 asynchronously, and no restart occurs until `i_play_start` falls and rises again.
